// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared types and helpers for the receive side of the text link.
//   rx_state_t     : message sink state (IDLE, CAPTURE, DRAIN, DONE)
//   DEF_TERM_CHAR  : default end-of-message character
//   DEF_REPL_CHAR  : default stand-in for an uncorrectable character
//   sat_inc8()     : 8-bit saturating increment used by link statistics blocks
// -----------------------------------------------------------------------------
package text_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } rx_state_t;

    localparam logic [7:0] DEF_TERM_CHAR = 8'h00;
    localparam logic [7:0] DEF_REPL_CHAR = 8'h3F;

    // Statistics must stick at the top value rather than wrap back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/text_rx_sink_if.sv
// -----------------------------------------------------------------------------
// text_rx_sink_if
// Character stream into the sink and the valid/ready stream out of it.
//   in_valid, in_data, in_err_corrected, in_err_fatal : decoded characters
//   out_valid, out_data, out_ready                    : consumer port
// Modports:
//   master : the side feeding characters and consuming the output
//   slave  : the sink itself
// -----------------------------------------------------------------------------
interface text_rx_sink_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_err_corrected;
    logic       in_err_fatal;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_data, in_err_corrected, in_err_fatal, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_err_corrected, in_err_fatal, out_ready,
        output out_valid, out_data
    );

endinterface

// File: rtl/text_fifo.sv
// -----------------------------------------------------------------------------
// text_fifo
// DEPTH x 8 synchronous first-word-fall-through FIFO. The head entry is
// readable the cycle after it is written. A push into a full FIFO is still
// taken when a pop happens on the same edge, since that pop frees the slot.
//   CLOCK_50  : clock
//   reset     : synchronous active-high, empties the FIFO
//   push      : write request, push_data is the character to store
//   pop       : read request, ignored while empty
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : occupancy, 0..DEPTH
//   head      : oldest entry, 0 while empty
// -----------------------------------------------------------------------------
module text_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count
    // alone, which lets the array map onto plain RAM cells.
    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // When full, wr_ptr == rd_ptr; the head read here is the old entry, and
    // the overwrite only lands at the edge that also retires it.
    assign head = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/text_rx_sink.sv
// -----------------------------------------------------------------------------
// text_rx_sink
// Receive-side message sink. Buffers one message of decoded characters,
// replacing uncorrectable ones, ends it on TERM_CHAR, and hands it to a
// consumer over valid/ready while keeping per-message statistics.
//   CLOCK_50     : clock
//   reset        : synchronous active-high, discards any partial message
//   start_write  : arms a new capture when seen in IDLE
//   bus          : character input and consumer output (slave modport)
//   busy         : capturing or draining
//   msg_done     : one-cycle pulse once the message has fully drained
//   msg_len      : characters stored for this message
//   corr_cnt     : corrected characters, saturating
//   fatal_cnt    : uncorrectable characters, saturating
//   overflow     : at least one character of this message was dropped
// -----------------------------------------------------------------------------
module text_rx_sink
    import text_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] TERM_CHAR = DEF_TERM_CHAR,
    parameter logic [7:0] REPL_CHAR = DEF_REPL_CHAR
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start_write,
    text_rx_sink_if.slave          bus,
    output logic                   busy,
    output logic                   msg_done,
    output logic [$clog2(DEPTH):0] msg_len,
    output logic [7:0]             corr_cnt,
    output logic [7:0]             fatal_cnt,
    output logic                   overflow
);

    rx_state_t state;
    rx_state_t next_state;

    logic                   char_seen;
    logic                   term_seen;
    logic                   push_req;
    logic                   push_drop;
    logic                   start_capture;
    logic [7:0]             store_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    assign char_seen     = (state == CAPTURE) & bus.in_valid;
    assign term_seen     = char_seen & (bus.in_data == TERM_CHAR);
    assign push_req      = char_seen & ~term_seen;
    assign start_capture = (state == IDLE) & start_write;
    assign store_data    = bus.in_err_fatal ? REPL_CHAR : bus.in_data;

    // Mirrors the FIFO acceptance rule: a full FIFO only refuses the push
    // when no pop frees a slot on the same edge (full implies non-empty, so
    // out_ready alone means a pop).
    assign push_drop = push_req & fifo_full & ~bus.out_ready;

    text_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .push      (push_req),
        .push_data (store_data),
        .pop       (bus.out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (bus.out_data)
    );

    assign bus.out_valid = ~fifo_empty;

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    // NOTE: next_state takes a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_write) next_state = CAPTURE;
            CAPTURE: if (term_seen)   next_state = DRAIN;
            DRAIN:   if (fifo_count == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy     = (state == CAPTURE) || (state == DRAIN);
        msg_done = (state == DONE);
    end

    // Per-message statistics: cleared when a capture starts, held otherwise.
    // NOTE: sequential state is updated with <= so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset || start_capture) begin
            msg_len   <= '0;
            corr_cnt  <= '0;
            fatal_cnt <= '0;
            overflow  <= 1'b0;
        end else if (push_req) begin
            // Error statistics cover dropped characters too; fatal wins.
            if (bus.in_err_fatal)
                fatal_cnt <= sat_inc8(fatal_cnt);
            else if (bus.in_err_corrected)
                corr_cnt <= sat_inc8(corr_cnt);

            if (push_drop)
                overflow <= 1'b1;
            else if (msg_len != '1)
                msg_len <= msg_len + 1'b1;
        end
    end

endmodule

// File: tb/tb_text_rx_sink.sv
// -----------------------------------------------------------------------------
// tb_text_rx_sink
// Self-checking bench for text_rx_sink. Expected stored characters go into a
// scoreboard queue as they are sent and are compared as the consumer pops.
// -----------------------------------------------------------------------------
module tb_text_rx_sink;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          start_write;
    logic          busy;
    logic          msg_done;
    logic [LW-1:0] msg_len;
    logic [7:0]    corr_cnt;
    logic [7:0]    fatal_cnt;
    logic          overflow;

    text_rx_sink_if bus ();

    text_rx_sink #(.DEPTH(DEPTH)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start_write (start_write),
        .bus         (bus.slave),
        .busy        (busy),
        .msg_done    (msg_done),
        .msg_len     (msg_len),
        .corr_cnt    (corr_cnt),
        .fatal_cnt   (fatal_cnt),
        .overflow    (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] sb [$];
    int         exp_len;
    logic [7:0] exp_corr;
    logic [7:0] exp_fatal;
    logic       exp_ovf;

    // Consumer-side scoreboard: every pop must match the oldest expected byte.
    always @(negedge CLOCK_50) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL pop_unexpected: got out_data=%h with nothing expected", bus.out_data);
            end else begin
                logic [7:0] want;
                want = sb.pop_front();
                if (bus.out_data !== want)
                    $display("FAIL pop_data: got %h want %h", bus.out_data, want);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic start_msg();
        start_write = 1'b1;
        tick();
        start_write = 1'b0;
        exp_len   = 0;
        exp_corr  = 8'd0;
        exp_fatal = 8'd0;
        exp_ovf   = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy);
        else n_pass++;
        n_total++;
        if (msg_len !== '0 || overflow !== 1'b0)
            $display("FAIL start_clear: got len=%0d ovf=%b want 0 0", msg_len, overflow);
        else n_pass++;
    endtask

    // Sends one non-terminator character and updates the reference model.
    task automatic send_char(input logic [7:0] data, input logic corr, input logic fatal);
        bit accept;
        accept = (sb.size() < DEPTH) || (bus.out_ready && sb.size() > 0);
        if (accept) begin
            sb.push_back(fatal ? 8'h3F : data);
            exp_len++;
        end else begin
            exp_ovf = 1'b1;
        end
        if (fatal)     exp_fatal = (exp_fatal == 8'hFF) ? exp_fatal : exp_fatal + 8'd1;
        else if (corr) exp_corr  = (exp_corr  == 8'hFF) ? exp_corr  : exp_corr  + 8'd1;
        bus.in_valid         = 1'b1;
        bus.in_data          = data;
        bus.in_err_corrected = corr;
        bus.in_err_fatal     = fatal;
        tick();
        bus.in_valid         = 1'b0;
        bus.in_err_corrected = 1'b0;
        bus.in_err_fatal     = 1'b0;
    endtask

    task automatic send_term(input logic flags);
        bus.in_valid         = 1'b1;
        bus.in_data          = 8'h00;
        bus.in_err_corrected = flags;
        bus.in_err_fatal     = flags;
        tick();
        bus.in_valid         = 1'b0;
        bus.in_err_corrected = 1'b0;
        bus.in_err_fatal     = 1'b0;
    endtask

    // Waits (bounded) for msg_done, checks the held statistics in that cycle,
    // then confirms the pulse lasts a single cycle.
    task automatic wait_done(input string tag, input bit chk_len);
        int pulses = 0;
        bit seen   = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (msg_done === 1'b1) begin
                seen = 1;
                pulses++;
                n_total++;
                if (corr_cnt !== exp_corr || fatal_cnt !== exp_fatal)
                    $display("FAIL %s_errcnt: got corr=%0d fatal=%0d want %0d %0d",
                             tag, corr_cnt, fatal_cnt, exp_corr, exp_fatal);
                else n_pass++;
                n_total++;
                if (overflow !== exp_ovf)
                    $display("FAIL %s_overflow: got %b want %b", tag, overflow, exp_ovf);
                else n_pass++;
                if (chk_len) begin
                    n_total++;
                    if (int'(msg_len) !== exp_len)
                        $display("FAIL %s_len: got %0d want %0d", tag, msg_len, exp_len);
                    else n_pass++;
                end
                n_total++;
                if (sb.size() != 0)
                    $display("FAIL %s_drained: got %0d left want 0", tag, sb.size());
                else n_pass++;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            if (msg_done === 1'b1) pulses++;
            tick();
        end
        n_total++;
        if (pulses != 1) $display("FAIL %s_done_pulses: got %0d want 1", tag, pulses);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00)
            $display("FAIL reset_out: got valid=%b data=%h want 0 00", bus.out_valid, bus.out_data);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || msg_done !== 1'b0)
            $display("FAIL reset_ctrl: got busy=%b done=%b want 0 0", busy, msg_done);
        else n_pass++;
        n_total++;
        if (msg_len !== '0 || corr_cnt !== 8'd0 || fatal_cnt !== 8'd0 || overflow !== 1'b0)
            $display("FAIL reset_stats: got len=%0d corr=%0d fatal=%0d ovf=%b want 0",
                     msg_len, corr_cnt, fatal_cnt, overflow);
        else n_pass++;
    endtask

    task automatic test_hi();
        bus.out_ready = 1'b1;
        start_msg();
        send_char(8'h48, 1'b0, 1'b0);
        send_char(8'h49, 1'b0, 1'b0);
        send_term(1'b0);
        wait_done("hi", 1'b1);
        n_total++;
        if (busy !== 1'b0) $display("FAIL hi_idle_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_errors();
        bus.out_ready = 1'b1;
        start_msg();
        send_char(8'h41, 1'b1, 1'b0);
        send_char(8'h41, 1'b0, 1'b1);
        send_char(8'h41, 1'b1, 1'b1);
        send_term(1'b1);
        wait_done("err", 1'b1);
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        start_msg();
        for (int i = 0; i < 20; i++) send_char(8'h61 + 8'(i), 1'b0, 1'b0);
        send_term(1'b0);
        tick();
        n_total++;
        if (int'(msg_len) !== DEPTH || overflow !== 1'b1)
            $display("FAIL ovf_stall: got len=%0d ovf=%b want %0d 1", msg_len, overflow, DEPTH);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b1)
            $display("FAIL ovf_hold: got busy=%b valid=%b want 1 1", busy, bus.out_valid);
        else n_pass++;
        bus.out_ready = 1'b1;
        wait_done("ovf", 1'b1);
    endtask

    task automatic test_full_push_pop();
        bus.out_ready = 1'b0;
        start_msg();
        for (int i = 0; i < DEPTH; i++) send_char(8'h10 + 8'(i), 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        send_char(8'h80, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        n_total++;
        if (overflow !== 1'b0 || int'(msg_len) !== DEPTH + 1)
            $display("FAIL full_pushpop: got ovf=%b len=%0d want 0 %0d", overflow, msg_len, DEPTH + 1);
        else n_pass++;
        send_char(8'h81, 1'b0, 1'b0);
        n_total++;
        if (overflow !== 1'b1) $display("FAIL full_drop: got ovf=%b want 1", overflow);
        else n_pass++;
        bus.out_ready = 1'b1;
        send_term(1'b0);
        wait_done("full", 1'b1);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus.out_ready = 1'b0;
        start_msg();
        for (int i = 0; i < 5; i++) send_char(8'h30 + 8'(i), 1'b1, (i == 2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        n_total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rstmid_ctrl: got valid=%b busy=%b want 0 0", bus.out_valid, busy);
        else n_pass++;
        n_total++;
        if (msg_len !== '0 || corr_cnt !== 8'd0 || fatal_cnt !== 8'd0 || overflow !== 1'b0)
            $display("FAIL rstmid_stats: got len=%0d corr=%0d fatal=%0d ovf=%b want 0",
                     msg_len, corr_cnt, fatal_cnt, overflow);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (msg_done === 1'b1) pulses++;
            tick();
        end
        n_total++;
        if (pulses != 0) $display("FAIL rstmid_done: got %0d pulses want 0", pulses);
        else n_pass++;
    endtask

    task automatic test_saturate();
        bus.out_ready = 1'b1;
        start_msg();
        for (int i = 0; i < 260; i++) send_char(8'h55, 1'b0, 1'b1);
        send_term(1'b0);
        wait_done("sat", 1'b0);
        n_total++;
        if (fatal_cnt !== 8'hFF) $display("FAIL sat_fatal: got %0d want 255", fatal_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit armed = 0;
        bus.out_ready = 1'b1;
        start_write   = 1'b1;
        tick();
        exp_len = 0; exp_corr = 8'd0; exp_fatal = 8'd0; exp_ovf = 1'b0;
        send_char(8'h41, 1'b1, 1'b0);
        send_char(8'h42, 1'b0, 1'b0);
        send_term(1'b0);
        wait_done("b2b1", 1'b1);
        for (int i = 0; i < 10 && !armed; i++) begin
            if (busy === 1'b1) armed = 1;
            else tick();
        end
        start_write = 1'b0;
        n_total++;
        if (!armed) $display("FAIL b2b_rearm: got busy=%b want 1", busy);
        else n_pass++;
        n_total++;
        if (msg_len !== '0 || corr_cnt !== 8'd0)
            $display("FAIL b2b_clear: got len=%0d corr=%0d want 0 0", msg_len, corr_cnt);
        else n_pass++;
        exp_len = 0; exp_corr = 8'd0; exp_fatal = 8'd0; exp_ovf = 1'b0;
        send_char(8'h43, 1'b0, 1'b0);
        send_char(8'h44, 1'b0, 1'b0);
        send_char(8'h45, 1'b0, 1'b0);
        send_term(1'b0);
        wait_done("b2b2", 1'b1);
    endtask

    initial begin
        reset                = 1'b1;
        start_write          = 1'b0;
        bus.in_valid         = 1'b0;
        bus.in_data          = 8'h00;
        bus.in_err_corrected = 1'b0;
        bus.in_err_fatal     = 1'b0;
        bus.out_ready        = 1'b0;
        exp_len              = 0;
        exp_corr             = 8'd0;
        exp_fatal            = 8'd0;
        exp_ovf              = 1'b0;

        test_reset();
        test_hi();
        test_errors();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_saturate();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
